// File: rtl/fpu_unit_arbiter.sv
// fpu_unit_arbiter
//   Round-robin arbiter/sequencer sharing one multi-cycle FPU functional unit
//   among NUM_REQ requester ports. A granted request is acked, launched on the
//   unit, watched by a timeout counter and returned to its owner through a
//   valid/ready response.
//
// Ports
//   clk, reset                       rising-edge clock, synchronous active-high reset
//   req_valid/req_abort [NUM_REQ]    per-port request and abort
//   req_operand_a/b                  packed operands, port i at [i*DATA_W +: DATA_W]
//   req_ack [NUM_REQ]                one-cycle one-hot grant pulse
//   rsp_valid/rsp_ready [NUM_REQ]    one-hot response handshake
//   rsp_result, rsp_flags            shared response data, flags {inv,ovf,unf,inx}
//   unit_start/unit_abort            one-cycle launch / cancel pulses to the unit
//   unit_operand1/2                  latched operands for the unit
//   unit_done/unit_result/unit_flags completion from the unit
//   busy                             arbiter not idle
//   timeout_err                      one-cycle pulse when the watchdog fires
module fpu_unit_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_operand_a,
  input  logic [NUM_REQ*DATA_W-1:0]   req_operand_b,
  input  logic [NUM_REQ-1:0]          req_abort,
  output logic [NUM_REQ-1:0]          req_ack,
  output logic [NUM_REQ-1:0]          rsp_valid,
  input  logic [NUM_REQ-1:0]          rsp_ready,
  output logic [DATA_W-1:0]           rsp_result,
  output logic [3:0]                  rsp_flags,
  output logic                        unit_start,
  output logic                        unit_abort,
  output logic [DATA_W-1:0]           unit_operand1,
  output logic [DATA_W-1:0]           unit_operand2,
  input  logic                        unit_done,
  input  logic [DATA_W-1:0]           unit_result,
  input  logic [3:0]                  unit_flags,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t              state, state_d;
  logic [OW-1:0]       owner, owner_d;
  logic [OW-1:0]       last_grant, last_grant_d;
  logic [TW-1:0]       timer, timer_d;

  logic [NUM_REQ-1:0]  req_ack_d, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_result_d, operand1_d, operand2_d;
  logic [3:0]          rsp_flags_d;
  logic                unit_start_d, unit_abort_d, timeout_err_d, busy_d;

  logic                grant_found;
  logic [OW-1:0]       grant_idx, cand;
  logic [DATA_W-1:0]   grant_a, grant_b;
  logic [NUM_REQ-1:0]  grant_onehot, owner_onehot;

  // Rotating search starting just after the last completed owner.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = OW'((32'(last_grant) + i) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
    grant_a = '0;
    grant_b = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == OW'(i)) begin
        grant_a = req_operand_a[i*DATA_W +: DATA_W];
        grant_b = req_operand_b[i*DATA_W +: DATA_W];
      end
    end
    grant_onehot            = '0;
    grant_onehot[grant_idx] = 1'b1;
    owner_onehot            = '0;
    owner_onehot[owner]     = 1'b1;
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d       = state;
    owner_d       = owner;
    last_grant_d  = last_grant;
    timer_d       = timer;
    req_ack_d     = '0;
    unit_start_d  = 1'b0;
    unit_abort_d  = 1'b0;
    timeout_err_d = 1'b0;
    rsp_valid_d   = rsp_valid;
    rsp_result_d  = rsp_result;
    rsp_flags_d   = rsp_flags;
    operand1_d    = unit_operand1;
    operand2_d    = unit_operand2;

    case (state)
      S_IDLE: begin
        if (grant_found) begin
          state_d      = S_ISSUE;
          owner_d      = grant_idx;
          operand1_d   = grant_a;
          operand2_d   = grant_b;
          req_ack_d    = grant_onehot;
          unit_start_d = 1'b1;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        timer_d = '0;
      end
      S_WAIT: begin
        if (req_abort[owner]) begin
          unit_abort_d = 1'b1;
          state_d      = S_IDLE;
        end else if (unit_done) begin
          rsp_result_d = unit_result;
          rsp_flags_d  = unit_flags;
          rsp_valid_d  = owner_onehot;
          state_d      = S_RESP;
        end else if (timer == TIMER_LAST) begin
          rsp_result_d  = '0;
          rsp_flags_d   = 4'b1000;
          rsp_valid_d   = owner_onehot;
          timeout_err_d = 1'b1;
          state_d       = S_RESP;
        end else begin
          timer_d = timer + 1'b1;
        end
      end
      S_RESP: begin
        if (req_abort[owner]) begin
          rsp_valid_d = '0;
          state_d     = S_IDLE;
        end else if (rsp_ready[owner]) begin
          rsp_valid_d  = '0;
          last_grant_d = owner;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      owner         <= '0;
      last_grant    <= OW'(NUM_REQ - 1);
      timer         <= '0;
      req_ack       <= '0;
      rsp_valid     <= '0;
      rsp_result    <= '0;
      rsp_flags     <= '0;
      unit_start    <= 1'b0;
      unit_abort    <= 1'b0;
      unit_operand1 <= '0;
      unit_operand2 <= '0;
      busy          <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      state         <= state_d;
      owner         <= owner_d;
      last_grant    <= last_grant_d;
      timer         <= timer_d;
      req_ack       <= req_ack_d;
      rsp_valid     <= rsp_valid_d;
      rsp_result    <= rsp_result_d;
      rsp_flags     <= rsp_flags_d;
      unit_start    <= unit_start_d;
      unit_abort    <= unit_abort_d;
      unit_operand1 <= operand1_d;
      unit_operand2 <= operand2_d;
      busy          <= busy_d;
      timeout_err   <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_fpu_unit_arbiter.sv
// Testbench for fpu_unit_arbiter: directed stimulus, a transaction-level
// reference model updated on each rising edge, a compare process on the
// falling edge, and hand-computed literal checks in the stimulus.
module tb_fpu_unit_arbiter;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_abort, rsp_ready;
  logic [N*DW-1:0] req_operand_a, req_operand_b;
  logic [N-1:0]    req_ack, rsp_valid;
  logic [DW-1:0]   rsp_result, unit_operand1, unit_operand2, unit_result;
  logic [3:0]      rsp_flags, unit_flags;
  logic            unit_start, unit_abort, unit_done, busy, timeout_err;

  fpu_unit_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_operand_a(req_operand_a), .req_operand_b(req_operand_b),
    .req_abort(req_abort), .req_ack(req_ack),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .unit_start(unit_start), .unit_abort(unit_abort),
    .unit_operand1(unit_operand1), .unit_operand2(unit_operand2),
    .unit_done(unit_done), .unit_result(unit_result), .unit_flags(unit_flags),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // own = -1 means the unit is free. The watchdog is tracked as an absolute
  // edge deadline measured from the grant edge.
  int          edge_no = 0;
  int          own = -1, last = N - 1, grant_edge = 0;
  bit          responding = 0;
  logic [N-1:0] m_ack, m_valid;
  logic         m_start, m_abort, m_to, m_busy;
  logic [DW-1:0] m_res, m_op1, m_op2;
  logic [3:0]   m_flags;

  always @(posedge clk) begin
    edge_no++;
    m_ack = '0; m_start = 0; m_abort = 0; m_to = 0;
    if (reset) begin
      own = -1; last = N - 1; responding = 0;
      m_valid = '0; m_res = '0; m_flags = '0; m_op1 = '0; m_op2 = '0;
    end else if (own < 0) begin
      for (int k = 1; k <= N; k++) begin
        int p;
        p = (last + k) % N;
        if (own < 0 && req_valid[p[1:0]]) begin
          own = p; grant_edge = edge_no; responding = 0;
          m_op1 = req_operand_a[p*DW +: DW];
          m_op2 = req_operand_b[p*DW +: DW];
          m_ack[p[1:0]] = 1'b1; m_start = 1'b1;
        end
      end
    end else if (responding) begin
      if (req_abort[own[1:0]]) begin
        m_valid = '0; own = -1; responding = 0;
      end else if (rsp_ready[own[1:0]]) begin
        m_valid = '0; last = own; own = -1; responding = 0;
      end
    end else if (edge_no >= grant_edge + 2) begin
      if (req_abort[own[1:0]]) begin
        m_abort = 1'b1; own = -1;
      end else if (unit_done) begin
        m_res = unit_result; m_flags = unit_flags; responding = 1;
        m_valid = '0; m_valid[own[1:0]] = 1'b1;
      end else if (edge_no == grant_edge + TMO + 1) begin
        m_res = '0; m_flags = 4'b1000; m_to = 1'b1; responding = 1;
        m_valid = '0; m_valid[own[1:0]] = 1'b1;
      end
    end
    m_busy = (own >= 0);
  end

  always @(negedge clk) begin
    if (edge_no > 0) begin
      check("req_ack", req_ack, m_ack);
      check("unit_start", unit_start, m_start);
      check("unit_abort", unit_abort, m_abort);
      check("timeout_err", timeout_err, m_to);
      check("busy", busy, m_busy);
      check("rsp_valid", rsp_valid, m_valid);
      check("rsp_result", rsp_result, m_res);
      check("rsp_flags", rsp_flags, m_flags);
      check("unit_operand1", unit_operand1, m_op1);
      check("unit_operand2", unit_operand2, m_op2);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  int grants[6];
  int gaps[5];
  int exp_order[6] = '{0, 1, 2, 3, 0, 1};
  int ng, last_c;
  logic prev_start;

  initial begin
    reset = 1; req_valid = '0; req_abort = '0; rsp_ready = '0;
    unit_done = 0; unit_result = '0; unit_flags = '0;
    req_operand_a = {32'hA3, 32'h12, 32'hA1, 32'hA0};
    req_operand_b = {32'hB3, 32'h34, 32'hB1, 32'hB0};
    tick(); tick(); tick();
    check("reset_busy", busy, 1'b0);
    check("reset_ack", req_ack, 4'b0000);
    check("reset_result", rsp_result, 32'h0);
    reset = 0;

    // Single request from port 2.
    req_valid = 4'b0100;
    tick();                                        // T+1
    check("single_ack", req_ack, 4'b0100);
    check("single_start", unit_start, 1'b1);
    check("single_op1", unit_operand1, 32'h12);
    check("single_op2", unit_operand2, 32'h34);
    req_valid = '0;
    tick();                                        // T+2
    tick();                                        // T+3
    unit_done = 1; unit_result = 32'h46; unit_flags = 4'h0;
    tick();                                        // T+4
    unit_done = 0; unit_result = 32'hFFFF;
    check("single_rsp_valid", rsp_valid, 4'b0100);
    check("single_result", rsp_result, 32'h46);
    rsp_ready = 4'b1011;                           // non-owner readies only
    for (int i = 0; i < 3; i++) begin
      tick();
      check("single_hold_result", rsp_result, 32'h46);
      check("single_hold_valid", rsp_valid, 4'b0100);
    end
    rsp_ready = 4'b0100;
    tick();
    rsp_ready = '0;
    check("single_done_busy", busy, 1'b0);

    // Fairness from reset priority.
    reset = 1; tick(); tick(); reset = 0;
    req_valid = 4'hF; rsp_ready = 4'hF; ng = 0; last_c = 0; prev_start = 0;
    for (int c = 0; c < 60 && !(ng >= 6 && !busy); c++) begin
      tick();
      unit_done = prev_start; unit_result = 32'hA0 + c; unit_flags = c[3:0];
      prev_start = unit_start;
      if (req_ack != 0 && ng < 6) begin
        for (int k = 0; k < N; k++) if (req_ack[k]) grants[ng] = k;
        if (ng > 0) gaps[ng-1] = c - last_c;
        last_c = c;
        ng++;
        if (ng == 6) req_valid = '0;
      end
    end
    unit_done = 0; rsp_ready = '0; req_valid = '0;
    check("fair_count", ng, 6);
    for (int k = 0; k < 6; k++) check("fair_order", grants[k], exp_order[k]);
    for (int k = 0; k < 5; k++) check("fair_spacing", gaps[k], 4);

    // Watchdog: last completed owner is 1, so port 0 gets in via wrap.
    req_valid = 4'b0001;
    tick();                                        // T+1
    check("wd_start", unit_start, 1'b1);
    req_valid = '0;
    repeat (8) tick();                             // T+9
    check("wd_early", timeout_err, 1'b0);
    tick();                                        // T+10
    check("wd_timeout", timeout_err, 1'b1);
    check("wd_rsp_valid", rsp_valid, 4'b0001);
    check("wd_result", rsp_result, 32'h0);
    check("wd_flags", rsp_flags, 4'b1000);
    rsp_ready = 4'b0001; tick(); rsp_ready = '0;

    // Abort on port 1 in the second WAIT cycle; non-owner abort earlier.
    req_valid = 4'b0010;
    tick();                                        // T+1 ISSUE
    req_valid = '0;
    tick();                                        // T+2 first WAIT
    req_abort = 4'b0100;
    tick();                                        // T+3 second WAIT
    req_abort = 4'b0010;
    tick();                                        // T+4
    req_abort = '0;
    check("abort_pulse", unit_abort, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_no_rsp", rsp_valid, 4'b0000);
    req_valid = 4'b1010;
    tick();
    check("abort_regrant", req_ack, 4'b0010);
    req_valid = '0;

    // unit_done on the last watchdog cycle wins over the timeout.
    repeat (8) tick();
    unit_done = 1; unit_result = 32'h77; unit_flags = 4'b0001;
    tick();
    unit_done = 0;
    check("coll_no_timeout", timeout_err, 1'b0);
    check("coll_result", rsp_result, 32'h77);
    check("coll_flags", rsp_flags, 4'b0001);
    check("coll_valid", rsp_valid, 4'b0010);
    rsp_ready = 4'b0010; tick(); rsp_ready = '0;

    // unit_done together with owner abort: abort wins.
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    tick();
    unit_done = 1; unit_result = 32'h99; req_abort = 4'b1000;
    tick();
    unit_done = 0; req_abort = '0;
    check("coll2_abort", unit_abort, 1'b1);
    check("coll2_no_rsp", rsp_valid, 4'b0000);
    tick();
    check("coll2_still_no_rsp", rsp_valid, 4'b0000);

    // Reset during WAIT, then a stray unit_done.
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    tick();
    reset = 1;
    tick();
    reset = 0;
    check("rst_wait_busy", busy, 1'b0);
    check("rst_wait_op1", unit_operand1, 32'h0);
    check("rst_wait_abort", unit_abort, 1'b0);
    unit_done = 1; unit_result = 32'hDEAD;
    tick();
    unit_done = 0;
    check("rst_stray_valid", rsp_valid, 4'b0000);
    check("rst_stray_result", rsp_result, 32'h0);

    // Reset during RESP.
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    tick();
    unit_done = 1; unit_result = 32'h55; unit_flags = 4'b0100;
    tick();
    unit_done = 0;
    check("rst_resp_pre", rsp_valid, 4'b0100);
    reset = 1;
    tick();
    reset = 0;
    check("rst_resp_valid", rsp_valid, 4'b0000);
    check("rst_resp_result", rsp_result, 32'h0);
    check("rst_resp_flags", rsp_flags, 4'b0000);
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
